reg_bank8: RTL and testbench

REG_BANK8 -- requirements
Module: reg_bank8

---
 rtl/reg_bank8_pkg.sv | 13 +
 rtl/reg_bank8_if.sv | 27 ++
 rtl/reg_bank8_clr_seq.sv | 42 ++++
 rtl/reg_bank8.sv | 80 ++++++++
 tb/tb_reg_bank8.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/reg_bank8_pkg.sv
// rtl/reg_bank8_pkg.sv - shared constants and FSM encoding for reg_bank8
package reg_bank8_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int NUM_ENTRIES = 8;
    localparam int ADDR_W      = 3;
    localparam logic [3:0] CNT_MAX = 4'd15;

endpackage

// File: rtl/reg_bank8_if.sv
// rtl/reg_bank8_if.sv - write/clear handshake and entry outputs of reg_bank8
interface reg_bank8_if
    import reg_bank8_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              clr_req;
    logic              busy;
    logic [WIDTH-1:0]  q0, q1, q2, q3, q4, q5, q6, q7;
    logic [3:0]        wr_cnt;

    modport master (
        output wr_valid, wr_addr, wr_data, clr_req,
        input  wr_ready, busy, wr_cnt,
        input  q0, q1, q2, q3, q4, q5, q6, q7
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, clr_req,
        output wr_ready, busy, wr_cnt,
        output q0, q1, q2, q3, q4, q5, q6, q7
    );
endinterface

// File: rtl/reg_bank8_clr_seq.sv
// rtl/reg_bank8_clr_seq.sv - IDLE/CLEAR sequencer walking the clear index 0..7
module reg_bank8_clr_seq
    import reg_bank8_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx
);
    state_t            state;
    logic [ADDR_W-1:0] idx;

    // State and index advance; clr_req is only looked at in IDLE so a repeat pulse cannot restart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        idx   <= '0;
                    end
                end
                CLEAR: begin
                    idx <= idx + 3'd1;
                    if (idx == 3'(NUM_ENTRIES - 1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state == CLEAR);
    assign clr_we  = (state == CLEAR);
    assign clr_idx = idx;
endmodule

// File: rtl/reg_bank8.sv
// rtl/reg_bank8.sv - 8-entry register bank with sequential clear; optional REG_BANK8_BYPASS_EN write-through
module reg_bank8
    import reg_bank8_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
)(
    input logic        clk,
    input logic        rst_n,
    reg_bank8_if.slave bus
);
    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic              accept;
    logic              clr_start;
    logic [3:0]        cnt;
    logic [WIDTH-1:0]  entry  [NUM_ENTRIES];
    logic [WIDTH-1:0]  q_view [NUM_ENTRIES];

    reg_bank8_clr_seq u_clr_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (bus.clr_req),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_idx (clr_idx)
    );

    assign accept    = bus.wr_valid && !busy;
    assign clr_start = bus.clr_req && !busy;

    // Entry storage: writes happen only in IDLE, clears only in CLEAR, so they never collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entry[i] <= CLR_VAL;
            end
        end else if (clr_we) begin
            entry[clr_idx] <= CLR_VAL;
        end else if (accept) begin
            entry[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Accepted-write counter; entering CLEAR wins over a same-edge write increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr_start) begin
            cnt <= '0;
        end else if (accept && cnt != CNT_MAX) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Output view of the entries, optionally showing the in-flight write data
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            q_view[i] = entry[i];
`ifdef REG_BANK8_BYPASS_EN
            if (accept && bus.wr_addr == ADDR_W'(i)) begin
                q_view[i] = bus.wr_data;
            end
`endif
        end
    end

    assign bus.wr_ready = !busy;
    assign bus.busy     = busy;
    assign bus.wr_cnt   = cnt;
    assign bus.q0       = q_view[0];
    assign bus.q1       = q_view[1];
    assign bus.q2       = q_view[2];
    assign bus.q3       = q_view[3];
    assign bus.q4       = q_view[4];
    assign bus.q5       = q_view[5];
    assign bus.q6       = q_view[6];
    assign bus.q7       = q_view[7];
endmodule

// File: tb/tb_reg_bank8.sv
// tb/tb_reg_bank8.sv - scoreboard bench for reg_bank8 against a behavioural model
module tb_reg_bank8;
    localparam int         WIDTH = 8;
    localparam logic [7:0] CLR   = 8'h00;

    typedef struct packed {
        logic [63:0] qv;
        logic        busy;
        logic        ready;
        logic [3:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_bank8_if #(.WIDTH(WIDTH)) bus ();

    reg_bank8 #(.WIDTH(WIDTH), .CLR_VAL(CLR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cycle_no    = 0;

    logic [7:0] mem [8];
    int         clear_left;
    int         cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mem[i] = CLR;
        clear_left = 0;
        cnt        = 0;
    endtask

    // One cycle: drive inputs, push what the outputs must show this cycle, then advance the model across the edge
    task automatic step(input bit rn, input bit v, input logic [2:0] a, input logic [7:0] d, input bit clr);
        exp_t e;
        bit   busy_m;
        bit   acc;
        @(posedge clk);
        #1;
        rst_n        = rn;
        bus.wr_valid = v;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.clr_req  = clr;
        if (!rn) model_reset();
        busy_m = (clear_left > 0);
        acc    = rn && v && !busy_m;
        for (int i = 0; i < 8; i++) e.qv[i*8 +: 8] = mem[i];
`ifdef REG_BANK8_BYPASS_EN
        if (acc) e.qv[int'(a)*8 +: 8] = d;
`endif
        e.busy  = busy_m;
        e.ready = !busy_m;
        e.cnt   = 4'(cnt);
        exp_q.push_back(e);
        if (rn) begin
            if (busy_m) begin
                mem[8 - clear_left] = CLR;
                clear_left--;
            end else begin
                if (acc) begin
                    mem[a] = d;
                    cnt    = (cnt >= 15) ? 15 : cnt + 1;
                end
                if (clr) begin
                    clear_left = 8;
                    cnt        = 0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    // Monitor: every cycle the outputs are compared against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cycle_no++;
                chk($sformatf("q c%0d", cycle_no),
                    {bus.q7, bus.q6, bus.q5, bus.q4, bus.q3, bus.q2, bus.q1, bus.q0}, e.qv);
                chk($sformatf("busy c%0d", cycle_no), 64'(bus.busy), 64'(e.busy));
                chk($sformatf("wr_ready c%0d", cycle_no), 64'(bus.wr_ready), 64'(e.ready));
                chk($sformatf("wr_cnt c%0d", cycle_no), 64'(bus.wr_cnt), 64'(e.cnt));
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.clr_req  = 1'b0;
        model_reset();

        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 3'd2, 8'hEE, 1'b1);
        step(1'b1, 1'b1, 3'd3, 8'hA5, 1'b0);
        idle(2);

        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 3'(i), 8'h10 + 8'(i), 1'b0);
        step(1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 3'(i), 8'hFF, (i == 3));
        idle(2);

        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 1'b0);
        idle(1);

        step(1'b1, 1'b1, 3'd5, 8'h77, 1'b1);
        idle(10);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'(i + 4), 8'hC0 + 8'(i), 1'b0);
        step(1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
        idle(4);
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        idle(1);

        step(1'b1, 1'b1, 3'd7, 8'h3C, 1'b0);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)),
                 8'($urandom),
                 ($urandom_range(0, 15) == 0));
        end
        idle(3);

        @(negedge clk);
        #1;
        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
